// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver. Samples the synchronized serial line at mid-bit,
// holds one received byte for the CPU bus and reports framing/overrun errors.
module uart_rx #(
    parameter int unsigned BAUD_DIV = 217
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx,
    input  logic       i_ack,
    input  logic       i_clr_err,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam int unsigned CNT_W     = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned BIT_W     = 3;
    localparam int unsigned DATA_W    = 8;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(7);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                rx_meta_q, rx_s_q;

    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                ferr_q, ferr_d;
    logic                ovr_q, ovr_d;
    logic                busy_q;

    // Stop-bit outcome strobes, asserted in the cycle the stop bit is sampled.
    logic                stop_good_c;
    logic                stop_bad_c;

    // Two-flop synchronizer; resets to idle-high so reset release is not a start.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // State and receive datapath registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Next-state logic: bit timing, data shifting and stop-bit evaluation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        bit_d       = bit_q;
        shift_d     = shift_q;
        stop_good_c = 1'b0;
        stop_bad_c  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    bit_d = '0;
                    // A line that is high again at mid-start-bit was a glitch.
                    state_d = rx_s_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[DATA_W-1:1]};
                    if (bit_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        stop_good_c = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        stop_bad_c = 1'b1;
                        state_d    = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // Hold off new starts until the line returns high.
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output next values: delivery, acknowledge and sticky error flags.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
        if (i_clr_err) begin
            ferr_d = 1'b0;
            ovr_d  = 1'b0;
        end
        if (i_ack && valid_q) begin
            valid_d = 1'b0;
        end
        // Delivery and error setting come last so they win over ack/clear.
        if (stop_good_c) begin
            if (!valid_q || i_ack) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
        if (stop_bad_c) begin
            ferr_d = 1'b1;
        end
    end

    // Output registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_overrun   = ovr_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with a byte scoreboard.
module tb_uart_rx;

    localparam int unsigned BD = 8;

    logic       clk;
    logic       i_reset;
    logic       i_rx;
    logic       i_ack;
    logic       i_clr_err;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_overrun;
    logic       o_busy;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic       prev_valid = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    uart_rx #(.BAUD_DIV(BD)) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_rx       (i_rx),
        .i_ack      (i_ack),
        .i_clr_err  (i_clr_err),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_frame_err(o_frame_err),
        .o_overrun  (o_overrun),
        .o_busy     (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: a delivery is o_valid rising or o_data changing while valid.
    always @(negedge clk) begin
        if (o_valid === 1'b1 && (prev_valid !== 1'b1 || o_data !== prev_data)) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_delivery: observed=%h expected=none", o_data);
            end
            if (exp_q.size() != 0) begin
                chk("sb_data", o_data, exp_q.pop_front());
            end
        end
        prev_valid = o_valid;
        prev_data  = o_data;
    end

    // Drive one frame starting at a negedge; ends at a negedge 10 bit times later.
    task automatic send_frame(input logic [7:0] b, input logic stop_v,
                              input bit ack_stop, input bit chk_lat);
        i_rx = 1'b0;
        repeat (BD) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            i_rx = b[k];
            repeat (BD) @(negedge clk);
        end
        i_rx = stop_v;
        for (int c = 0; c < int'(BD); c++) begin
            if (chk_lat && c == 6) chk("lat_before", 8'(o_valid), 8'h00);
            if (chk_lat && c == 7) chk("lat_at79", 8'(o_valid), 8'h01);
            if (ack_stop && c == 6) i_ack = 1'b1;
            if (c == 7) i_ack = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic pulse_ack();
        i_ack = 1'b1;
        @(negedge clk);
        i_ack = 1'b0;
    endtask

    task automatic pulse_clr();
        i_clr_err = 1'b1;
        @(negedge clk);
        i_clr_err = 1'b0;
    endtask

    initial begin
        logic seen_busy;
        i_reset   = 1'b1;
        i_rx      = 1'b1;
        i_ack     = 1'b0;
        i_clr_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data", o_data, 8'h00);
        chk("rst_valid", 8'(o_valid), 8'h00);
        chk("rst_flags", 8'({o_frame_err, o_overrun, o_busy}), 8'h00);
        i_reset = 1'b0;
        repeat (4) @(negedge clk);

        // 1: single byte, latency, ack
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        chk("t1_data", o_data, 8'hA5);
        chk("t1_ferr", 8'(o_frame_err), 8'h00);
        chk("t1_busy", 8'(o_busy), 8'h00);
        pulse_ack();
        chk("t1_ack_valid", 8'(o_valid), 8'h00);
        chk("t1_ack_data", o_data, 8'hA5);

        // 2: back-to-back without ack -> overrun
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        chk("t2_data_kept", o_data, 8'h3C);
        chk("t2_overrun", 8'(o_overrun), 8'h01);
        chk("t2_valid", 8'(o_valid), 8'h01);
        pulse_ack();
        pulse_clr();
        chk("t2_clr", 8'({o_valid, o_overrun, o_frame_err}), 8'h00);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        chk("t2_data_new", o_data, 8'h81);
        chk("t2_flags", 8'({o_overrun, o_frame_err}), 8'h00);
        pulse_ack();

        // 3: framing error then held break
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        repeat (30 * BD) @(negedge clk);
        chk("t3_ferr", 8'(o_frame_err), 8'h01);
        chk("t3_busy_break", 8'(o_busy), 8'h01);
        chk("t3_valid", 8'(o_valid), 8'h00);
        i_rx = 1'b1;
        repeat (BD) @(negedge clk);
        chk("t3_idle", 8'(o_busy), 8'h00);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1, 1'b0, 1'b0);
        chk("t3_data", o_data, 8'h12);
        chk("t3_ferr_sticky", 8'({o_frame_err, o_overrun}), 8'h02);
        pulse_clr();
        chk("t3_clr", 8'(o_frame_err), 8'h00);

        // 4: short glitch on idle line (0x12 still unread)
        i_rx = 1'b0;
        repeat (2) @(negedge clk);
        i_rx = 1'b1;
        seen_busy = 1'b0;
        for (int c = 0; c < int'(BD / 2 + 3); c++) begin
            @(negedge clk);
            seen_busy = seen_busy | o_busy;
        end
        chk("t4_seen_busy", 8'(seen_busy), 8'h01);
        chk("t4_busy_done", 8'(o_busy), 8'h00);
        chk("t4_state", {o_data[6:0], o_valid}, {7'h12, 1'b1});
        chk("t4_flags", 8'({o_frame_err, o_overrun}), 8'h00);

        // 5: reset during bit 4
        i_rx = 1'b0;
        repeat (BD) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            i_rx = k[0];
            repeat (BD) @(negedge clk);
        end
        i_rx = 1'b1;
        repeat (BD / 2) @(negedge clk);
        chk("t5_busy_pre", 8'(o_busy), 8'h01);
        i_reset = 1'b1;
        #1;
        chk("t5_rst_data", o_data, 8'h00);
        chk("t5_rst_ctl", 8'({o_valid, o_frame_err, o_overrun, o_busy}), 8'h00);
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        repeat (2 * BD) @(negedge clk);
        exp_q.push_back(8'hF0);
        send_frame(8'hF0, 1'b1, 1'b0, 1'b0);
        chk("t5_data", o_data, 8'hF0);
        chk("t5_flags", 8'({o_frame_err, o_overrun}), 8'h00);

        // 6: ack in the exact stop-sample cycle while valid is held
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, 1'b1, 1'b0);
        chk("t6_data", o_data, 8'h7E);
        chk("t6_valid", 8'(o_valid), 8'h01);
        chk("t6_overrun", 8'(o_overrun), 8'h00);

        repeat (4) @(negedge clk);
        chk("sb_drained", 8'(exp_q.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
